// File: rtl/clock_pkg.sv
// Shared definitions for the clock: edit-field encodings and BCD arithmetic
// helpers used by the timekeeping core.
package clock_pkg;

  typedef enum logic [1:0] {
    FLD_SEC = 2'd0,
    FLD_MIN = 2'd1,
    FLD_HR  = 2'd2
  } field_t;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = max;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // 00 -> 12, 13..23 -> 01..11, 01..12 unchanged; done in binary then re-encoded.
  function automatic logic [7:0] hr_to_12(input logic [7:0] v);
    logic [6:0] b;
    b = (7'(v[7:4]) * 7'd10) + 7'(v[3:0]);
    if (b == 7'd0) begin
      b = 7'd12;
    end else if (b > 7'd12) begin
      b = b - 7'd12;
    end else begin
      b = b;
    end
    return (b >= 7'd10) ? {4'd1, 4'(b - 7'd10)} : {4'd0, 4'(b)};
  endfunction

endpackage

// File: rtl/time_core_key_repeat.sv
// Press-edge step generator with hold-to-repeat for one active-low adjust key.
module key_repeat #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic key_n,
  output logic step
);

  localparam int MAXP = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW   = $clog2(MAXP + 1);

  logic          r_key_d;
  logic          r_rep;
  logic [CW-1:0] r_cnt;
  logic          w_press;
  logic          w_held;
  logic          w_fire;

  // r_cnt counts held cycles since the press (press cycle = 1); zero means idle,
  // so a key already low when the block becomes enabled never auto-repeats.
  assign w_press = enable & ~key_n & r_key_d;
  assign w_held  = enable & ~key_n & ~r_key_d & (r_cnt != '0);
  assign w_fire  = w_held & (r_rep ? (r_cnt == CW'(REPEAT_PER))
                                   : (r_cnt == CW'(REPEAT_DLY - 1)));
  assign step    = w_press | w_fire;

  // Edge register and repeat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_d <= 1'b1;
      r_cnt   <= '0;
      r_rep   <= 1'b0;
    end else begin
      r_key_d <= key_n;
      if (!enable || key_n) begin
        r_cnt <= '0;
        r_rep <= 1'b0;
      end else if (w_press) begin
        r_cnt <= CW'(1);
        r_rep <= 1'b0;
      end else if (w_fire) begin
        r_cnt <= CW'(1);
        r_rep <= 1'b1;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt + CW'(1);
        r_rep <= r_rep;
      end else begin
        r_cnt <= r_cnt;
        r_rep <= r_rep;
      end
    end
  end

endmodule

// File: rtl/time_core.sv
// BCD hh:mm:ss timekeeping core: 1 Hz run mode, field-select set mode with
// repeating adjust keys, 12/24-hour display and a midnight rollover pulse.
module time_core
  import clock_pkg::*;
#(
  parameter int         REPEAT_DLY = 50_000_000,
  parameter int         REPEAT_PER = 10_000_000,
  parameter logic [7:0] INIT_HR    = 8'h12,
  parameter logic [7:0] INIT_MIN   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       set_mode,
  input  logic       key_sel_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic       mode12,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [3:0] hr_lo,
  output logic [3:0] hr_hi,
  output logic       pm,
  output logic [1:0] field,
  output logic       day_pulse
);

  logic [7:0] r_sec, r_min, r_hr;
  field_t     r_field;
  logic       r_day, r_set_d, r_sel_d;

  logic [7:0] w_sec_n, w_min_n, w_hr_n, w_hr_disp;
  field_t     w_field_n;
  logic       w_adj_en, w_up, w_dn, w_sel_edge, w_set_rise, w_run_tick, w_rollover;

  // Both keys held cancels stepping and keeps both repeat counters clear.
  assign w_adj_en   = set_mode & (key_up_n | key_dn_n);
  assign w_sel_edge = set_mode & ~key_sel_n & r_sel_d;
  assign w_set_rise = set_mode & ~r_set_d;
  assign w_run_tick = ~set_mode & tick_1hz;
  assign w_rollover = w_run_tick & (r_sec == SEC_MAX) & (r_min == MIN_MAX) & (r_hr == HR_MAX);

  key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_rep_up (
    .clk(clk), .rst(rst), .enable(w_adj_en), .key_n(key_up_n), .step(w_up)
  );

  key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_rep_dn (
    .clk(clk), .rst(rst), .enable(w_adj_en), .key_n(key_dn_n), .step(w_dn)
  );

  // Next time: adjust the selected field alone in set mode, carry chain in run mode.
  always_comb begin
    w_sec_n = r_sec;
    w_min_n = r_min;
    w_hr_n  = r_hr;
    if (set_mode) begin
      if (w_up || w_dn) begin
        case (r_field)
          FLD_SEC: w_sec_n = 8'h00;
          FLD_MIN: w_min_n = w_up ? bcd_inc(r_min, MIN_MAX) : bcd_dec(r_min, MIN_MAX);
          FLD_HR:  w_hr_n  = w_up ? bcd_inc(r_hr, HR_MAX) : bcd_dec(r_hr, HR_MAX);
          default: w_sec_n = r_sec;
        endcase
      end else begin
        w_sec_n = r_sec;
      end
    end else if (tick_1hz) begin
      w_sec_n = bcd_inc(r_sec, SEC_MAX);
      if (r_sec == SEC_MAX) begin
        w_min_n = bcd_inc(r_min, MIN_MAX);
        if (r_min == MIN_MAX) begin
          w_hr_n = bcd_inc(r_hr, HR_MAX);
        end else begin
          w_hr_n = r_hr;
        end
      end else begin
        w_min_n = r_min;
      end
    end else begin
      w_sec_n = r_sec;
    end
  end

  // Next field: entering set mode selects minutes, sel edges rotate sec/min/hr.
  always_comb begin
    w_field_n = r_field;
    if (w_set_rise) begin
      w_field_n = FLD_MIN;
    end else if (w_sel_edge) begin
      case (r_field)
        FLD_SEC: w_field_n = FLD_MIN;
        FLD_MIN: w_field_n = FLD_HR;
        FLD_HR:  w_field_n = FLD_SEC;
        default: w_field_n = FLD_MIN;
      endcase
    end else begin
      w_field_n = r_field;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec   <= 8'h00;
      r_min   <= INIT_MIN;
      r_hr    <= INIT_HR;
      r_field <= FLD_MIN;
      r_day   <= 1'b0;
      r_set_d <= 1'b0;
      r_sel_d <= 1'b1;
    end else begin
      r_sec   <= w_sec_n;
      r_min   <= w_min_n;
      r_hr    <= w_hr_n;
      r_field <= w_field_n;
      r_day   <= w_rollover;
      r_set_d <= set_mode;
      r_sel_d <= key_sel_n;
    end
  end

  assign w_hr_disp = mode12 ? hr_to_12(r_hr) : r_hr;

  assign sec_lo    = r_sec[3:0];
  assign sec_hi    = r_sec[7:4];
  assign min_lo    = r_min[3:0];
  assign min_hi    = r_min[7:4];
  assign hr_lo     = w_hr_disp[3:0];
  assign hr_hi     = w_hr_disp[7:4];
  assign pm        = (r_hr >= 8'h12);
  assign field     = r_field;
  assign day_pulse = r_day;

endmodule

// File: tb/tb_time_core.sv
// Self-checking bench for time_core: table of operations with expected
// readings fed through a scoreboard queue, plus hand sequences for corners.
module tb_time_core;

  localparam int DLY = 8;
  localparam int PER = 4;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, set_mode, key_sel_n, key_up_n, key_dn_n, mode12;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic       pm, day_pulse;
  logic [1:0] field;

  int n_checks = 0;
  int n_err    = 0;

  time_core #(.REPEAT_DLY(DLY), .REPEAT_PER(PER), .INIT_HR(8'h12), .INIT_MIN(8'h00)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .set_mode(set_mode),
    .key_sel_n(key_sel_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n), .mode12(mode12),
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .hr_lo(hr_lo), .hr_hi(hr_hi), .pm(pm), .field(field), .day_pulse(day_pulse)
  );

  always #5 clk = ~clk;

  typedef enum {OP_CHK, OP_SET, OP_RUN, OP_UP, OP_DN, OP_SEL, OP_TICK} op_e;

  typedef struct {
    op_e        op;
    int         n;
    logic       m12;
    logic [23:0] t;
    logic [1:0] f;
    logic       pm;
  } vec_t;

  typedef struct {
    string       name;
    logic [23:0] t;
    logic [1:0]  f;
    logic        pm;
    logic        day;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [23:0] t, input logic [1:0] f,
                            input logic p, input logic d);
    exp_t e;
    e.name = name; e.t = t; e.f = f; e.pm = p; e.day = d;
    sbq.push_back(e);
  endtask

  // Pops the oldest expectation and compares it with the DUT on the falling edge.
  task automatic check_out();
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sbq.pop_front();
      chk({e.name, ".time"}, {8'h0, hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo}, {8'h0, e.t});
      chk({e.name, ".field"}, {30'h0, field}, {30'h0, e.f});
      chk({e.name, ".pm"}, {31'h0, pm}, {31'h0, e.pm});
      chk({e.name, ".day"}, {31'h0, day_pulse}, {31'h0, e.day});
    end
  endtask

  task automatic run_op(input op_e op, input int n);
    case (op)
      OP_SET:  begin set_mode = 1'b1; cyc(2); end
      OP_RUN:  begin set_mode = 1'b0; cyc(2); end
      OP_UP:   for (int i = 0; i < n; i++) begin key_up_n = 1'b0; cyc(1); key_up_n = 1'b1; cyc(1); end
      OP_DN:   for (int i = 0; i < n; i++) begin key_dn_n = 1'b0; cyc(1); key_dn_n = 1'b1; cyc(1); end
      OP_SEL:  for (int i = 0; i < n; i++) begin key_sel_n = 1'b0; cyc(1); key_sel_n = 1'b1; cyc(1); end
      OP_TICK: for (int i = 0; i < n; i++) begin tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0; cyc(1); end
      default: cyc(1);
    endcase
  endtask

  task automatic apply_vecs(input string tag);
    vec_t v;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      mode12 = v.m12;
      expect_out($sformatf("%s_%s_%0d", tag, v.op.name(), v.n), v.t, v.f, v.pm, 1'b0);
      run_op(v.op, v.n);
      check_out();
    end
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; set_mode = 1'b0; mode12 = 1'b0;
    key_sel_n = 1'b1; key_up_n = 1'b1; key_dn_n = 1'b1;
    cyc(3);
    rst = 1'b0;
    expect_out("reset", 24'h120000, 2'd1, 1'b1, 1'b0);
    check_out();

    // Walk to 23:59:59 through set mode and run-mode ticks.
    vecs.push_back('{OP_SET,  0, 1'b0, 24'h120000, 2'd1, 1'b1});
    vecs.push_back('{OP_DN,   1, 1'b0, 24'h125900, 2'd1, 1'b1});
    vecs.push_back('{OP_UP,   1, 1'b0, 24'h120000, 2'd1, 1'b1});
    vecs.push_back('{OP_DN,   1, 1'b0, 24'h125900, 2'd1, 1'b1});
    vecs.push_back('{OP_SEL,  1, 1'b0, 24'h125900, 2'd2, 1'b1});
    vecs.push_back('{OP_DN,  13, 1'b0, 24'h235900, 2'd2, 1'b1});
    vecs.push_back('{OP_TICK, 5, 1'b0, 24'h235900, 2'd2, 1'b1});
    vecs.push_back('{OP_SEL,  2, 1'b0, 24'h235900, 2'd1, 1'b1});
    vecs.push_back('{OP_RUN,  0, 1'b0, 24'h235900, 2'd1, 1'b1});
    vecs.push_back('{OP_TICK,58, 1'b0, 24'h235958, 2'd1, 1'b1});
    vecs.push_back('{OP_TICK, 1, 1'b0, 24'h235959, 2'd1, 1'b1});
    apply_vecs("a");

    // Midnight rollover: pulse coincides with 00:00:00 and lasts one cycle.
    tick_1hz = 1'b1;
    expect_out("midnight", 24'h000000, 2'd1, 1'b0, 1'b1);
    cyc(1);
    tick_1hz = 1'b0;
    check_out();
    expect_out("midnight_after", 24'h000000, 2'd1, 1'b0, 1'b0);
    check_out();

    vecs.push_back('{OP_SET,  0, 1'b0, 24'h000000, 2'd1, 1'b0});
    vecs.push_back('{OP_UP,  15, 1'b0, 24'h001500, 2'd1, 1'b0});
    vecs.push_back('{OP_CHK,  0, 1'b1, 24'h121500, 2'd1, 1'b0});
    vecs.push_back('{OP_SEL,  1, 1'b0, 24'h001500, 2'd2, 1'b0});
    vecs.push_back('{OP_UP,  13, 1'b0, 24'h131500, 2'd2, 1'b1});
    vecs.push_back('{OP_RUN,  0, 1'b0, 24'h131500, 2'd2, 1'b1});
    vecs.push_back('{OP_TICK, 7, 1'b0, 24'h131507, 2'd2, 1'b1});
    vecs.push_back('{OP_SET,  0, 1'b0, 24'h131507, 2'd1, 1'b1});
    vecs.push_back('{OP_SEL,  2, 1'b0, 24'h131507, 2'd0, 1'b1});
    vecs.push_back('{OP_UP,   1, 1'b0, 24'h131500, 2'd0, 1'b1});
    vecs.push_back('{OP_SEL,  1, 1'b0, 24'h131500, 2'd1, 1'b1});
    vecs.push_back('{OP_DN,  10, 1'b0, 24'h130500, 2'd1, 1'b1});
    vecs.push_back('{OP_CHK,  0, 1'b1, 24'h010500, 2'd1, 1'b1});
    vecs.push_back('{OP_SEL,  1, 1'b0, 24'h130500, 2'd2, 1'b1});
    vecs.push_back('{OP_UP,   9, 1'b0, 24'h220500, 2'd2, 1'b1});
    apply_vecs("b");

    // Hold up for DLY + 3*PER cycles with ticks arriving: five steps 22 -> 03.
    expect_out("repeat_hold", 24'h030500, 2'd2, 1'b0, 1'b0);
    key_up_n = 1'b0;
    for (int i = 0; i < DLY + 3 * PER; i++) begin
      tick_1hz = (i % 3 == 1);
      cyc(1);
    end
    key_up_n = 1'b1;
    tick_1hz = 1'b0;
    cyc(2);
    check_out();

    // Both keys held together: no steps at all.
    expect_out("both_held", 24'h030500, 2'd2, 1'b0, 1'b0);
    key_up_n = 1'b0;
    key_dn_n = 1'b0;
    cyc(3 * DLY);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    cyc(2);
    check_out();

    // Reset in the middle of a hold, key released while reset is applied.
    expect_out("pre_reset_press", 24'h040500, 2'd2, 1'b0, 1'b0);
    key_up_n = 1'b0;
    cyc(3);
    check_out();
    rst = 1'b1;
    key_up_n = 1'b1;
    expect_out("mid_hold_reset", 24'h120000, 2'd1, 1'b1, 1'b0);
    cyc(1);
    check_out();
    rst = 1'b0;
    expect_out("after_reset_idle", 24'h120000, 2'd1, 1'b1, 1'b0);
    cyc(DLY + 2 * PER);
    check_out();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/time_core.md
# time_core

Parametrised BCD timekeeping core for the digital clock: keeps hh:mm:ss as six BCD digits on a single system clock, advanced by a one-cycle 1 Hz enable pulse. Provides a set mode with field select, increment and decrement, and hold-to-repeat on the adjust keys. Supports a runtime 12/24-hour display mode and a midnight rollover pulse. It sits between the 1 Hz prescaler / key debouncers and the display multiplexer.

## Interface
- `REPEAT_DLY`, 50_000_000: cycles an adjust key must be held before auto-repeat starts.
- `REPEAT_PER`, 10_000_000: cycles between auto-repeat steps.
- `INIT_HR`, 8'h12: BCD hour loaded at reset (24-hour form).
- `INIT_MIN`, 8'h00: BCD minute loaded at reset.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `tick_1hz`  in  1  one-cycle enable, once per second.
- `set_mode`  in  1  1 = set mode: time is frozen and editable.
- `key_sel_n`  in  1  field-select key, active-low, already debounced.
- `key_up_n`  in  1  increment key, active-low, already debounced.
- `key_dn_n`  in  1  decrement key, active-low, already debounced.
- `mode12`  in  1  1 = 12-hour display, 0 = 24-hour display.
- `sec_lo`, `sec_hi`, `min_lo`, `min_hi`, `hr_lo`, `hr_hi`  out  4 each  BCD display digits.
- `pm`  out  1  1 when internal hour ≥ 12. Valid in both display modes.
- `field`  out  2  field being edited: 0 = seconds, 1 = minutes, 2 = hours.
- `day_pulse`  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 rollover.

## Operation
- **Internal time**
  - Always held as 24-hour BCD.
  - Digit ranges: `sec_lo`/`min_lo` 0–9, `sec_hi`/`min_hi` 0–5, hours 00–23.
  - No digit ever holds a non-BCD value.
- **Run mode** (`set_mode`=0): each `tick_1hz` advances time by 1 s with full carry chain 59 s → min, 59 min → hr, 23 → 00.
- **Set mode** (`set_mode`=1):
  - `tick_1hz` is ignored (dropped, not queued).
  - The rising edge of `set_mode` loads `field` = 1.
  - A falling edge of `key_sel_n` steps `field` 0 → 1 → 2 → 0. `field` never takes value 3.
- **Adjust steps**, applied to the selected field only, with no carry into other fields:
  - Minutes: up 59 → 00, down 00 → 59.
  - Hours: up 23 → 00, down 00 → 23.
  - Seconds: up or down clears the seconds to 00.
- **Key repeat**
  - Press edge: one step.
  - Continuous hold of `REPEAT_DLY` cycles: one further step, then one step every `REPEAT_PER` cycles while held.
  - Up and down both held: no steps, and both repeat counters are held clear.
  - Keys are ignored outside set mode, and their repeat counters are cleared.
- **Display**
  - `mode12`=0: hours are shown as stored.
  - `mode12`=1: internal 00 shows 12; 13–23 show 01–11; 01–12 are unchanged.
  - `hr_hi` is shown as 0, not blanked; blanking is the display block's job.
- **Reset**
  - Time loads `INIT_HR`:`INIT_MIN`:00.
  - `field`=1, `day_pulse`=0, key edge registers = released (1), repeat counters = 0.

## Timing
- All state updates on the `clk` edge where the qualifying input is sampled.
- Digit outputs, `pm` and `field` are combinational from registers, so they reflect the change in the following cycle.
- Key edges are detected against a one-cycle-delayed copy of the key. The step lands 1 cycle after the key is first sampled low.
- `day_pulse` is registered and high for exactly one cycle, coincident with the time reading 00:00:00.
- **Simultaneous events**
  - `tick_1hz` in the same cycle as `set_mode` rising: the tick is dropped.
  - `set_mode` falling and `tick_1hz` in the same cycle: the tick is applied.
  - A sel edge and an adjust step in the same cycle: the step uses the old `field`.
- `rst` overrides all inputs in the same cycle, including mid-repeat.

## Structure
- Shared package `clock_pkg`:
  - Field encodings `FLD_SEC`/`FLD_MIN`/`FLD_HR`.
  - BCD increment/decrement functions taking a modulus.
  - 24 → 12-hour conversion function.
- Sub-module `key_repeat` (params `REPEAT_DLY`, `REPEAT_PER`):
  - In: `clk`, `rst`, `enable`, `key_n`. Out: `step` pulse.
  - One instance each for up and down.
  - Counter width is `$clog2` of the larger period.

## Test plan
- Reset → outputs read 12:00:00, `field`=1, `pm`=1, `day_pulse`=0.
- Preload 23:59:58, two ticks → 23:59:59 then 00:00:00; `day_pulse` high for that one cycle only.
- Set mode, `field`=1, minutes at 59, one up press → 00 with hours unchanged; down press at 00 → 59.
- Set mode, `field`=2, hold up for `REPEAT_DLY` + 3·`REPEAT_PER` cycles (small params) from 22 → exactly 5 steps giving 03; pulses on `tick_1hz` throughout leave seconds unchanged.
- `mode12`=1 at internal 00:15 and 13:05 → shows 12:15 `pm`=0 and 01:05 `pm`=1.
- Both keys held in set mode → no change; `rst` mid-hold → reset values next cycle, no step after release.
